// File: rtl/prog_sequencer.sv
// Program sequencer: launches up to three stored programs on the fetch unit, one per
// Go request, and reports completion, per-program cycle count and watchdog timeout.
module prog_sequencer #(
    parameter int               NUM_PROGS  = 3,
    parameter int               PC_W       = 11,
    parameter int               CYC_W      = 16,
    parameter int               START_HOLD = 2,
    parameter logic [PC_W-1:0]  BASE0      = PC_W'(0),
    parameter logic [PC_W-1:0]  BASE1      = PC_W'(256),
    parameter logic [PC_W-1:0]  BASE2      = PC_W'(512),
    parameter logic [CYC_W-1:0] TIMEOUT    = CYC_W'(16'hFFFF)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Go,
    input  logic             Halt,
    output logic             Start,
    output logic             LoadEn,
    output logic [PC_W-1:0]  LoadAddr,
    output logic             Busy,
    output logic             Done,
    output logic             Error,
    output logic [1:0]       ProgIdx,
    output logic [CYC_W-1:0] CycleCount,
    output logic             AllDone
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HOLD = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam int                HOLD_W    = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(START_HOLD - 1);
    localparam logic [1:0]        LAST_IDX  = 2'(NUM_PROGS - 1);

    logic [2:0]        state_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [CYC_W-1:0]  run_cnt;
    logic [CYC_W-1:0]  run_next;
    logic              run_end;
    logic [1:0]        prog_idx_q;
    logic [CYC_W-1:0]  cycle_count_q;
    logic              all_done_q;
    logic              err_q;

    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] c);
        return (c == {CYC_W{1'b1}}) ? c : c + CYC_W'(1);
    endfunction

    function automatic logic [PC_W-1:0] base_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    return BASE0;
            2'd1:    return BASE1;
            default: return BASE2;
        endcase
    endfunction

    // run_next is the program length counting the current cycle; Halt takes priority
    // over the watchdog when both land in the same cycle.
    assign run_next = sat_inc(run_cnt);
    assign run_end  = Halt || (run_next >= TIMEOUT);

    always_ff @(posedge Clk) begin
        case (state_q)
            S_IDLE:  hold_cnt <= '0;
            S_HOLD:  hold_cnt <= hold_cnt + HOLD_W'(1);
            default: hold_cnt <= hold_cnt;
        endcase
        if (state_q == S_LOAD) begin
            run_cnt <= CYC_W'(1);
        end else if (state_q == S_RUN) begin
            run_cnt <= run_next;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= S_IDLE;
            prog_idx_q    <= 2'd0;
            cycle_count_q <= '0;
            all_done_q    <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Go && !all_done_q) begin
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (run_end) begin
                        state_q       <= S_FIN;
                        err_q         <= ~Halt;
                        cycle_count_q <= run_next;
                        if (prog_idx_q == LAST_IDX) begin
                            all_done_q <= 1'b1;
                        end else begin
                            prog_idx_q <= prog_idx_q + 2'd1;
                        end
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Every output is a decode of registered state; Go and Halt only steer next state.
    assign Start      = (state_q == S_HOLD);
    assign LoadEn     = (state_q == S_LOAD);
    assign LoadAddr   = LoadEn ? base_addr(prog_idx_q) : '0;
    assign Busy       = (state_q == S_HOLD) || (state_q == S_LOAD) || (state_q == S_RUN);
    assign Done       = (state_q == S_FIN);
    assign Error      = Done && err_q;
    assign ProgIdx    = prog_idx_q;
    assign CycleCount = cycle_count_q;
    assign AllDone    = all_done_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: directed launch sequences with randomized Halt offsets,
// checked cycle by cycle against a program-level reference model.
module tb_prog_sequencer;

    localparam int NUM_PROGS  = 3;
    localparam int PC_W       = 11;
    localparam int CYC_W      = 16;
    localparam int START_HOLD = 2;
    localparam int TO         = 20;
    localparam int BASES [3]  = '{0, 256, 512};

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Go;
    logic             Halt;
    logic             Start;
    logic             LoadEn;
    logic [PC_W-1:0]  LoadAddr;
    logic             Busy;
    logic             Done;
    logic             Error;
    logic [1:0]       ProgIdx;
    logic [CYC_W-1:0] CycleCount;
    logic             AllDone;

    prog_sequencer #(
        .NUM_PROGS (NUM_PROGS),
        .PC_W      (PC_W),
        .CYC_W     (CYC_W),
        .START_HOLD(START_HOLD),
        .TIMEOUT   (CYC_W'(TO))
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Go        (Go),
        .Halt      (Halt),
        .Start     (Start),
        .LoadEn    (LoadEn),
        .LoadAddr  (LoadAddr),
        .Busy      (Busy),
        .Done      (Done),
        .Error     (Error),
        .ProgIdx   (ProgIdx),
        .CycleCount(CycleCount),
        .AllDone   (AllDone)
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    // Reference model: which program is next, whether all are finished, last length.
    int m_idx;
    bit m_all;
    int m_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_cycle(input string ph, input bit e_start, input bit e_load,
                               input bit e_busy, input bit e_done);
        chk({ph, " ctl"}, {28'd0, Start, LoadEn, Busy, Done},
            {28'd0, e_start, e_load, e_busy, e_done});
        chk({ph, " addr"}, 32'(LoadAddr), e_load ? 32'(BASES[m_idx]) : 32'd0);
        chk({ph, " idx"}, 32'(ProgIdx), 32'(m_idx));
        chk({ph, " cyc"}, 32'(CycleCount), 32'(m_cyc));
        chk({ph, " alldone"}, 32'(AllDone), 32'(m_all));
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Go    = 1'b0;
        Halt  = 1'b0;
        step();
        m_idx = 0;
        m_all = 1'b0;
        m_cyc = 0;
        check_cycle("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset err", 32'(Error), 32'd0);
        Reset = 1'b0;
    endtask

    task automatic idle(input int n, input bit go_val);
        for (int i = 0; i < n; i++) begin
            Go   = go_val;
            Halt = 1'($urandom_range(0, 1));
            step();
            check_cycle("idle", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        Go   = 1'b0;
        Halt = 1'b0;
    endtask

    // d = RUN cycle (1-based, after LoadEn) in which Halt is raised.
    task automatic launch(input int d, input bit hold_go, input bit noisy);
        int cnt;
        bit e_err;
        bit last;
        Go   = 1'b1;
        Halt = 1'b0;
        step();
        for (int h = 0; h < START_HOLD; h++) begin
            check_cycle("hold", 1'b1, 1'b0, 1'b1, 1'b0);
            Go   = hold_go;
            Halt = noisy;
            step();
        end
        check_cycle("load", 1'b0, 1'b1, 1'b1, 1'b0);
        Halt = noisy;
        step();
        for (int j = 1; j <= TO; j++) begin
            check_cycle("run", 1'b0, 1'b0, 1'b1, 1'b0);
            last = (j == d) || (j + 1 == TO);
            Halt = (j == d);
            if (noisy) Go = 1'b1;
            step();
            if (last) break;
        end
        cnt   = (d + 1 <= TO) ? d + 1 : TO;
        e_err = (d + 1 > TO);
        if (m_idx == NUM_PROGS - 1) m_all = 1'b1;
        else m_idx++;
        m_cyc = cnt;
        check_cycle("fin", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("fin err", 32'(Error), 32'(e_err));
        Halt = 1'b0;
        Go   = hold_go;
        step();
        check_cycle("gap", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        Reset = 1'b1;
        Go    = 1'b0;
        Halt  = 1'b0;
        m_idx = 0;
        m_all = 1'b0;
        m_cyc = 0;

        do_reset();
        idle(10, 1'b0);

        // Single launch, Halt in the fifth cycle after LoadEn.
        launch(5, 1'b0, 1'b0);
        chk("first cyclecount", 32'(CycleCount), 32'd6);
        chk("first progidx", 32'(ProgIdx), 32'd1);
        idle(2, 1'b0);

        // Halt during HOLD/LOAD and Go during RUN are ignored; no queued relaunch.
        launch(int'($urandom_range(1, 15)), 1'b0, 1'b1);
        idle(3, 1'b0);

        // Watchdog on the last program, then Go with AllDone set does nothing.
        launch(TO + 5, 1'b0, 1'b0);
        chk("timeout cyclecount", 32'(CycleCount), 32'(TO));
        idle(5, 1'b1);

        // Three back-to-back launches with Go held high, including Halt on the timeout cycle.
        do_reset();
        launch(int'($urandom_range(1, 25)), 1'b1, 1'b0);
        launch(TO - 1, 1'b1, 1'b0);
        launch(int'($urandom_range(1, 25)), 1'b1, 1'b0);
        chk("alldone after three", 32'(AllDone), 32'd1);
        idle(4, 1'b1);

        // Reset in the middle of program 1 aborts without a Done pulse.
        do_reset();
        launch(int'($urandom_range(1, 12)), 1'b0, 1'b0);
        Go = 1'b1;
        step();
        Go = 1'b0;
        for (int h = 0; h < START_HOLD; h++) step();
        check_cycle("p1 load", 1'b0, 1'b1, 1'b1, 1'b0);
        for (int j = 0; j < 4; j++) step();
        check_cycle("p1 run", 1'b0, 1'b0, 1'b1, 1'b0);
        Reset = 1'b1;
        step();
        m_idx = 0;
        m_all = 1'b0;
        m_cyc = 0;
        check_cycle("abort", 1'b0, 1'b0, 1'b0, 1'b0);
        Reset = 1'b0;
        step();
        check_cycle("post abort", 1'b0, 1'b0, 1'b0, 1'b0);

        // Clean restart from program 0.
        launch(int'($urandom_range(1, 10)), 1'b0, 1'b0);
        idle(2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
